shift_serial_ctrl: RTL and testbench
====================================

# shift_serial_ctrl

Sequencer and two-way round-robin arbiter for the team's n-bit shift-right register (parallel load `L`, load data `R`, serial fill `w`, shifts `Q[k] <= Q[k+1]` and `Q[n-1] <= w`). The block accepts parallel words from two requesters and loads the winner's word into the register. It then clocks out exactly `N` bits, LSB first, with a valid strobe, and signals completion. It sits between the requesters and the single shared shift register, which is instantiated alongside it.

## Interface
- `N`, 16, word width; must match the shift register's `n`; N ≥ 2
- `FILL`, 1'b0, value driven on `w` during shifting
- `Clk` input 1 rising-edge clock
- `Resetn` input 1 reset: one clock; reset is asynchronous and active-low
- `req0`, `req1` input 1 each; transfer request; held high until the matching `gnt`
- `data0`, `data1` input N each; word to send; stable while the matching `req` is high
- `gnt0`, `gnt1` output 1 each; one-cycle grant pulse
- `L` output 1; parallel-load strobe to the shift register
- `R` output N; load data to the shift register
- `w` output 1; serial fill to the shift register; constant `FILL`
- `Q0` input 1; shift register `Q[0]`
- `sout` output 1; serial data, equal to `Q0`, qualified by `sout_valid`
- `sout_valid` output 1; high during shift cycles
- `done` output 1; one-cycle pulse after the last bit
- `busy` output 1; high in every state except IDLE
- `owner` output 1; index of the current or last granted requester

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- **IDLE**
  - No request: stay in IDLE.
  - On a clock edge with any `req` high: arbitrate, latch the winner's data into `R`, set `owner`, and go to LOAD.
- **Arbitration**
  - Only one request high: that request wins.
  - Both high: the requester not equal to `last_owner` wins.
  - `last_owner` updates on each grant.
- **LOAD** (1 cycle)
  - `L`=1; `gnt[owner]`=1.
  - Next edge: the shift register loads `R`, the bit counter clears to 0, go to SHIFT.
- **SHIFT** (exactly N cycles)
  - `L`=0; `sout_valid`=1; `sout`=`Q0`.
  - The counter increments each edge.
  - Leave for DONE on the edge where counter = N-1.
- **DONE** (1 cycle)
  - `done`=1; the next edge goes to IDLE.
- Request timing:
  - Requests raised while `busy` wait in IDLE for arbitration. They are not lost.
  - A request that drops before being granted is ignored.
- `R` holds the last loaded word until the next grant.
- Counter width is `$clog2(N)`. It never wraps within a transfer.
- Reset mid-operation:
  - Immediately: state=IDLE, `L`=0, `sout_valid`=0, counter=0.
  - The transfer is abandoned and `done` is not pulsed.
  - Shift register contents are don't-care.

## Timing
- All outputs are registered, or decoded from state only, except `sout`, which passes `Q0` through combinationally.
- Reset values:
  - `gnt0`=`gnt1`=`L`=`sout_valid`=`done`=`busy`=0
  - `R`=0; `owner`=0; `last_owner`=1 (so requester 0 wins the first tie)
  - `w`=`FILL` always
- Latency and throughput:
  - Request edge in IDLE → LOAD cycle: 1 cycle.
  - First valid bit (word bit 0) is in the cycle after LOAD.
  - Bit k appears in SHIFT cycle k.
  - `done` appears N+1 cycles after LOAD.
  - Back-to-back minimum period per word: N+3 cycles (LOAD + N×SHIFT + DONE + IDLE).
- Simultaneous `req0` and `req1` across consecutive transfers alternate grants strictly.

## Structure
- Package `shift_ctrl_pkg`:
  - state encoding constants IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3
  - default `N`
- Sub-module `rr_arb2`: combinational two-request round-robin pick plus the `last_owner` register.
- The controller top contains:
  - the FSM
  - the bit counter
  - the `R`/`owner` latch
- The shift register is instantiated outside the controller; the controller's `L`, `R`, `w` and `Q0` connect to its ports.

## Test plan
- **Reset defaults:** assert `Resetn`=0 mid-run, then release → all outputs at reset values, state IDLE, no `done`.
- **Single transfer:** N=16, `req0`=1, `data0`=16'hA5C3 → `gnt0` pulses in LOAD, `L`=1 for one cycle. `sout` over 16 valid cycles = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. `done` follows one cycle later.
- **Tie after reset:** `req0` and `req1` both held from reset → grants alternate 0,1,0,1. Each word is serialized intact. The gap between `done` and the next `L` is 1 cycle.
- **Late request:** `req1` raised in SHIFT cycle 5 of a requester-0 transfer → `gnt1` in the LOAD that starts 2 cycles after that transfer's `done`. Transfer 0 bits are unaffected.
- **Fill and count:** `FILL`=1, `data0`=16'h0000 → exactly 16 `sout_valid` cycles, all `sout`=0, and `w`=1 throughout.
- **Reset during SHIFT:** `Resetn` pulsed low at SHIFT cycle 8 → `sout_valid` drops immediately. No `done`. After release, a new `req1` transfer completes normally.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: state encoding and default word width shared by the serial
// shift controller and its bench.
package shift_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;
    localparam int DEF_N = 16;
endpackage

// File: rtl/shift_serial_ctrl_rr_arb2.sv
// rr_arb2: two-request round-robin pick; on a tie the requester that did not
// win last time is chosen.
module rr_arb2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_grant,
    output logic o_win
);
    logic r_last_owner;
    assign o_win = (i_req0 & i_req1) ? ~r_last_owner : i_req1;
    // Reset to 1 so requester 0 takes the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_last_owner <= 1'b1;
        else if (i_grant) r_last_owner <= o_win;
    end
endmodule

// File: rtl/shift_serial_ctrl.sv
// shift_serial_ctrl: arbitrates two word requesters and sequences an external
// shift-right register to serialize the winning word LSB first.
module shift_serial_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int   N    = DEF_N,
    parameter logic FILL = 1'b0
) (
    input  logic         Clk,
    input  logic         Resetn,
    input  logic         req0,
    input  logic         req1,
    input  logic [N-1:0] data0,
    input  logic [N-1:0] data1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         L,
    output logic [N-1:0] R,
    output logic         w,
    input  logic         Q0,
    output logic         sout,
    output logic         sout_valid,
    output logic         done,
    output logic         busy,
    output logic         owner
);
    localparam int CW = $clog2(N);
    state_t r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic w_win, w_grant, w_last_bit;
    assign w_grant    = (r_state == IDLE) & (req0 | req1);
    assign w_last_bit = r_cnt == CW'(N - 1);
    rr_arb2 u_arb (
        .i_clk   (Clk),
        .i_rst_n (Resetn),
        .i_req0  (req0),
        .i_req1  (req1),
        .i_grant (w_grant),
        .o_win   (w_win)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_grant ? LOAD : IDLE;
            LOAD:    w_next = SHIFT;
            SHIFT:   w_next = w_last_bit ? DONE : SHIFT;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) r_state <= IDLE;
        else r_state <= w_next;
    end
    // Counter stops on the last bit so it never wraps inside a transfer.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) r_cnt <= '0;
        else if (r_state == LOAD) r_cnt <= '0;
        else if (r_state == SHIFT && !w_last_bit) r_cnt <= r_cnt + CW'(1);
    end
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            R     <= '0;
            owner <= 1'b0;
        end else if (w_grant) begin
            R     <= w_win ? data1 : data0;
            owner <= w_win;
        end
    end
    assign L          = r_state == LOAD;
    assign gnt0       = L & ~owner;
    assign gnt1       = L & owner;
    assign sout_valid = r_state == SHIFT;
    assign done       = r_state == DONE;
    assign busy       = r_state != IDLE;
    assign w          = FILL;
    assign sout       = Q0;
endmodule

// File: tb/tb_shift_serial_ctrl.sv
// tb_shift_serial_ctrl: directed plus randomized checks of the serial controller
// driving behavioural shift registers, against a transfer-level model.
module tb_shift_serial_ctrl;
    localparam int N = 16;
    logic Clk = 1'b0;
    logic Resetn = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [N-1:0] data0 = '0, data1 = '0;
    logic gnt0, gnt1, L, w, sout, sout_valid, done, busy, owner;
    logic [N-1:0] R;
    logic [N-1:0] q = '0;
    logic f_req0 = 1'b0;
    logic [N-1:0] f_data0 = '0;
    logic f_gnt0, f_gnt1, f_L, f_w, f_sout, f_valid, f_done, f_busy, f_owner;
    logic [N-1:0] f_R;
    logic [N-1:0] fq = '0;
    int n_chk = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    shift_serial_ctrl #(.N(N), .FILL(1'b0)) u_dut (
        .Clk(Clk), .Resetn(Resetn), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
        .L(L), .R(R), .w(w), .Q0(q[0]), .sout(sout),
        .sout_valid(sout_valid), .done(done), .busy(busy), .owner(owner)
    );
    shift_serial_ctrl #(.N(N), .FILL(1'b1)) u_dut_fill (
        .Clk(Clk), .Resetn(Resetn), .req0(f_req0), .req1(1'b0),
        .data0(f_data0), .data1('0), .gnt0(f_gnt0), .gnt1(f_gnt1),
        .L(f_L), .R(f_R), .w(f_w), .Q0(fq[0]), .sout(f_sout),
        .sout_valid(f_valid), .done(f_done), .busy(f_busy), .owner(f_owner)
    );

    // External shift-right registers the controllers drive.
    always @(posedge Clk) q  <= L ? R : {w, q[N-1:1]};
    always @(posedge Clk) fq <= f_L ? f_R : {f_w, fq[N-1:1]};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 32'({gnt0, gnt1}), 32'(0));
        chk({tag, "_L"}, 32'(L), 32'(0));
        chk({tag, "_valid"}, 32'(sout_valid), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_R"}, 32'(R), 32'(0));
        chk({tag, "_owner"}, 32'(owner), 32'(0));
    endtask

    // One transfer: wait for LOAD, check grant/owner/word, then N bits and done.
    // late_k raises req1 with late_d in that shift cycle; rst_k pulls reset there.
    task automatic xfer(input logic exp_own, input logic [N-1:0] exp_d, input int late_k,
                        input logic [N-1:0] late_d, input int rst_k, output int waited);
        logic seen;
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 40) begin
            @(negedge Clk);
            waited++;
            seen = L;
        end
        if (!seen) begin
            chk("load_timeout", 32'(0), 32'(1));
            return;
        end
        chk("gnt0", 32'(gnt0), 32'(!exp_own));
        chk("gnt1", 32'(gnt1), 32'(exp_own));
        chk("owner", 32'(owner), 32'(exp_own));
        chk("R", 32'(R), 32'(exp_d));
        if (exp_own) req1 = 1'b0;
        else req0 = 1'b0;
        for (int k = 0; k < N; k++) begin
            @(negedge Clk);
            if (k == late_k) begin
                req1  = 1'b1;
                data1 = late_d;
            end
            if (k == rst_k) begin
                Resetn = 1'b0;
                #1;
                chk_reset_outputs("rst_mid");
                return;
            end
            chk("valid", 32'(sout_valid), 32'(1));
            chk("bit", 32'(sout), 32'(exp_d[k]));
            chk("no_early_done", 32'(done), 32'(0));
        end
        @(negedge Clk);
        chk("done", 32'(done), 32'(1));
        chk("valid_off", 32'(sout_valid), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int wt, nv, ones, wbad, nd, m_last;
        logic p0, p1, win, saw_l;
        logic [N-1:0] d0, d1;
        repeat (3) @(negedge Clk);
        chk_reset_outputs("rst0");
        chk("w_fill0", 32'(w), 32'(0));
        chk("w_fill1", 32'(f_w), 32'(1));
        Resetn = 1'b1;
        // Single transfer of A5C3 from requester 0.
        req0 = 1'b1;
        data0 = 16'hA5C3;
        xfer(1'b0, 16'hA5C3, -1, '0, -1, wt);
        chk("req_latency", 32'(wt), 32'(1));
        // Tie held through reset: grants alternate starting with 0.
        @(negedge Clk);
        Resetn = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        data0 = N'($urandom);
        data1 = N'($urandom);
        @(negedge Clk);
        Resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            win = 1'(i % 2);
            d0 = data0;
            d1 = data1;
            xfer(win, win ? d1 : d0, -1, '0, -1, wt);
            if (i > 0) chk("tie_gap", 32'(wt), 32'(2));
            if (win) begin
                req1 = 1'b1;
                data1 = N'($urandom);
            end else begin
                req0 = 1'b1;
                data0 = N'($urandom);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        // Late request from 1 during requester 0's shift cycle 5.
        @(negedge Clk);
        req0 = 1'b1;
        data0 = N'($urandom);
        d0 = data0;
        d1 = N'($urandom);
        xfer(1'b0, d0, 5, d1, -1, wt);
        xfer(1'b1, d1, -1, '0, -1, wt);
        chk("late_gap", 32'(wt), 32'(2));
        // FILL=1 instance with an all-zero word.
        f_req0 = 1'b1;
        saw_l = 1'b0;
        for (int i = 0; i < 10 && !saw_l; i++) begin
            @(negedge Clk);
            saw_l = f_L;
        end
        chk("fill_load", 32'(saw_l), 32'(1));
        chk("fill_gnt", 32'({f_gnt0, f_gnt1, f_owner}), 32'(3'b100));
        f_req0 = 1'b0;
        nv = 0; ones = 0; wbad = 0; nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (f_valid) begin
                nv++;
                if (f_sout) ones++;
            end
            if (!f_w) wbad++;
            if (f_done) nd++;
        end
        chk("fill_valid_cnt", 32'(nv), 32'(N));
        chk("fill_ones", 32'(ones), 32'(0));
        chk("fill_w", 32'(wbad), 32'(0));
        chk("fill_done_cnt", 32'(nd), 32'(1));
        chk("fill_idle", 32'(f_busy), 32'(0));
        // Reset pulled during shift cycle 8, then a fresh requester-1 transfer.
        req0 = 1'b1;
        data0 = N'($urandom);
        xfer(1'b0, data0, -1, '0, 8, wt);
        nd = 0;
        repeat (2) begin
            @(negedge Clk);
            if (done || busy) nd++;
        end
        Resetn = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            if (done || busy) nd++;
        end
        chk("rst_no_done", 32'(nd), 32'(0));
        chk_reset_outputs("rst_rel");
        req1 = 1'b1;
        data1 = N'($urandom);
        xfer(1'b1, data1, -1, '0, -1, wt);
        // Randomized traffic against the round-robin model.
        m_last = 1;
        p0 = 1'b0;
        p1 = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (!p0 && $urandom_range(1, 0) == 1) begin
                p0 = 1'b1; req0 = 1'b1; data0 = N'($urandom);
            end
            if (!p1 && $urandom_range(1, 0) == 1) begin
                p1 = 1'b1; req1 = 1'b1; data1 = N'($urandom);
            end
            if (!p0 && !p1) begin
                p0 = 1'b1; req0 = 1'b1; data0 = N'($urandom);
            end
            win = (p0 && p1) ? (m_last == 0) : p1;
            xfer(win, win ? data1 : data0, -1, '0, -1, wt);
            chk("rand_gap", 32'(wt), 32'(2));
            m_last = int'(win);
            if (win) p1 = 1'b0;
            else p0 = 1'b0;
        end
        repeat (3) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
